// File: rtl/dmem_lsu.sv
// RV32I load/store initiator for the data port of the unified memory.
// Splits word-crossing accesses into two word accesses and extends load data.
module dmem_lsu #(
    parameter bit SPLIT_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic [31:0] dmem_addr_o,
    output logic        dmem_ren_o,
    input  logic [31:0] dmem_rdata_i,
    output logic        dmem_wen_o,
    output logic [3:0]  dmem_wstrb_o,
    output logic [31:0] dmem_wdata_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ACC0 = 3'd1,
        S_ACC1 = 3'd2,
        S_WAIT = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    function automatic logic [3:0] size_mask(input logic [1:0] sz);
        logic [3:0] m;
        case (sz)
            2'b00:   m = 4'b0001;
            2'b01:   m = 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic crosses(input logic [1:0] off, input logic [1:0] sz);
        logic [2:0] n;
        case (sz)
            2'b00:   n = 3'd1;
            2'b01:   n = 3'd2;
            default: n = 3'd4;
        endcase
        return (({1'b0, off} + n) > 3'd4);
    endfunction

    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        logic bad;
        if (we) begin
            bad = (f3 != 3'b000) && (f3 != 3'b001) && (f3 != 3'b010);
        end else begin
            bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        end
        return bad;
    endfunction

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] lo_q, lo_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;

    logic [1:0]  off_s;
    logic        cross_s;
    logic [31:0] word0_s;
    logic [31:0] word1_s;
    logic [7:0]  mask8_s;
    logic [63:0] wd64_s;
    logic [63:0] r64_s;
    logic [31:0] field_s;
    logic [31:0] ext_s;

    // Lane alignment and load extraction derived from the captured request
    always_comb begin
        off_s   = addr_q[1:0];
        cross_s = crosses(off_s, f3_q[1:0]);
        word0_s = {addr_q[31:2], 2'b00};
        word1_s = word0_s + 32'd4;
        mask8_s = {4'b0000, size_mask(f3_q[1:0])} << off_s;
        wd64_s  = {32'h0000_0000, wdata_q} << {off_s, 3'b000};
        r64_s   = cross_s ? {dmem_rdata_i, lo_q} : {32'h0000_0000, dmem_rdata_i};
        field_s = 32'(r64_s >> {off_s, 3'b000});
        case (f3_q[1:0])
            2'b00:   ext_s = f3_q[2] ? {24'h00_0000, field_s[7:0]}
                                     : {{24{field_s[7]}}, field_s[7:0]};
            2'b01:   ext_s = f3_q[2] ? {16'h0000, field_s[15:0]}
                                     : {{16{field_s[15]}}, field_s[15:0]};
            default: ext_s = field_s;
        endcase
    end

    // Next-state, request capture, memory port drive and response staging
    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        f3_d         = f3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        lo_d         = lo_q;
        rsp_valid_d  = 1'b0;
        rsp_err_d    = 1'b0;
        rsp_rdata_d  = 32'h0000_0000;
        dmem_addr_o  = 32'h0000_0000;
        dmem_ren_o   = 1'b0;
        dmem_wen_o   = 1'b0;
        dmem_wstrb_o = 4'b0000;
        dmem_wdata_o = 32'h0000_0000;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    we_d    = req_we_i;
                    f3_d    = req_funct3_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    if (f3_illegal(req_we_i, req_funct3_i) ||
                        (crosses(req_addr_i[1:0], req_funct3_i[1:0]) && !SPLIT_EN)) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_ACC0;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACC0: begin
                dmem_addr_o = word0_s;
                if (we_q) begin
                    dmem_wen_o   = 1'b1;
                    dmem_wstrb_o = mask8_s[3:0];
                    dmem_wdata_o = wd64_s[31:0];
                end else begin
                    dmem_ren_o = 1'b1;
                end
                if (cross_s) begin
                    state_d = S_ACC1;
                end else if (we_q) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b1;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_ACC1: begin
                dmem_addr_o = word1_s;
                if (we_q) begin
                    dmem_wen_o   = 1'b1;
                    dmem_wstrb_o = mask8_s[7:4];
                    dmem_wdata_o = wd64_s[63:32];
                    state_d      = S_IDLE;
                    rsp_valid_d  = 1'b1;
                end else begin
                    // read data of the ACC0 access is on the bus this cycle
                    dmem_ren_o = 1'b1;
                    lo_d       = dmem_rdata_i;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                rsp_valid_d = 1'b1;
                rsp_rdata_d = ext_s;
                state_d     = S_IDLE;
            end
            S_ERR: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, captured request and registered response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            f3_q        <= 3'b000;
            addr_q      <= 32'h0000_0000;
            wdata_q     <= 32'h0000_0000;
            lo_q        <= 32'h0000_0000;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            f3_q        <= f3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            lo_q        <= lo_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign req_ready_o = (state_q == S_IDLE);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_rdata_o = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed self-checking bench for dmem_lsu with a word memory model behind the data port.
module tb_dmem_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_valid_b = 1'b0;
    logic        req_ready_o, req_ready_b;
    logic        req_we_i = 1'b0;
    logic [2:0]  req_funct3_i = 3'b000;
    logic [31:0] req_addr_i = 32'h0;
    logic [31:0] req_wdata_i = 32'h0;
    logic        rsp_valid_o, rsp_err_o;
    logic [31:0] rsp_rdata_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic        dmem_ren_o, dmem_wen_o;
    logic [3:0]  dmem_wstrb_o;
    logic [31:0] mem_rdata;
    logic        b_rsp_valid, b_rsp_err, b_ren, b_wen;
    logic [31:0] b_rsp_rdata, b_addr, b_wdata;
    logic [3:0]  b_wstrb;
    logic [31:0] b_rdata = 32'h0;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [0:1023];
    int          acc_total = 0;
    int          overlap_cnt = 0;
    logic        log_we    [0:255];
    logic [31:0] log_addr  [0:255];
    logic [3:0]  log_strb  [0:255];
    logic [31:0] log_wdata [0:255];

    dmem_lsu #(.SPLIT_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_funct3_i(req_funct3_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .dmem_addr_o(dmem_addr_o), .dmem_ren_o(dmem_ren_o), .dmem_rdata_i(mem_rdata),
        .dmem_wen_o(dmem_wen_o), .dmem_wstrb_o(dmem_wstrb_o), .dmem_wdata_o(dmem_wdata_o)
    );

    dmem_lsu #(.SPLIT_EN(1'b0)) dut_nosplit (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_b), .req_ready_o(req_ready_b), .req_we_i(req_we_i),
        .req_funct3_i(req_funct3_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(b_rsp_valid), .rsp_rdata_o(b_rsp_rdata), .rsp_err_o(b_rsp_err),
        .dmem_addr_o(b_addr), .dmem_ren_o(b_ren), .dmem_rdata_i(b_rdata),
        .dmem_wen_o(b_wen), .dmem_wstrb_o(b_wstrb), .dmem_wdata_o(b_wdata)
    );

    always #5 clk = ~clk;

    // Memory model: byte-strobed write, one-cycle read latency
    always @(posedge clk) begin
        if (dmem_wen_o) begin
            for (int i = 0; i < 4; i++) begin
                if (dmem_wstrb_o[i]) mem[dmem_addr_o[11:2]][8*i +: 8] <= dmem_wdata_o[8*i +: 8];
            end
        end
        if (dmem_ren_o) mem_rdata <= mem[dmem_addr_o[11:2]];
    end

    // Access log sampled mid-cycle
    always @(negedge clk) begin
        if (dmem_ren_o || dmem_wen_o) begin
            log_we[acc_total[7:0]]    <= dmem_wen_o;
            log_addr[acc_total[7:0]]  <= dmem_addr_o;
            log_strb[acc_total[7:0]]  <= dmem_wstrb_o;
            log_wdata[acc_total[7:0]] <= dmem_wdata_o;
            acc_total <= acc_total + 1;
        end
        if (dmem_ren_o && dmem_wen_o) overlap_cnt <= overlap_cnt + 1;
    end

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output int lat, output logic [31:0] rd,
                          output logic er, output int first);
        int k;
        k = 0;
        while (req_ready_o !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        first = acc_total;
        req_we_i = we; req_funct3_i = f3; req_addr_i = a; req_wdata_i = wd;
        req_valid_i = 1'b1;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        lat = -1; rd = 32'hxxxx_xxxx; er = 1'bx;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (rsp_valid_o === 1'b1) begin
                lat = c; rd = rsp_rdata_o; er = rsp_err_o;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #2;
        checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", req_ready_o); end
        checks++; if (rsp_valid_o !== 1'b0 || rsp_err_o !== 1'b0 || rsp_rdata_o !== 32'h0) begin
            errors++; $display("FAIL reset_rsp: got v=%b e=%b d=%h exp 0/0/0", rsp_valid_o, rsp_err_o, rsp_rdata_o); end
        checks++; if (dmem_ren_o !== 1'b0 || dmem_wen_o !== 1'b0 || dmem_addr_o !== 32'h0 ||
                      dmem_wstrb_o !== 4'h0 || dmem_wdata_o !== 32'h0) begin
            errors++; $display("FAIL reset_dmem: got r=%b w=%b a=%h s=%b d=%h exp all 0",
                               dmem_ren_o, dmem_wen_o, dmem_addr_o, dmem_wstrb_o, dmem_wdata_o); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_store();
        int lat, f; logic [31:0] rd; logic er;
        do_req(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, lat, rd, er, f);
        checks++; if (lat !== 2 || er !== 1'b0 || rd !== 32'h0) begin
            errors++; $display("FAIL sw_rsp: got lat=%0d err=%b d=%h exp 2/0/0", lat, er, rd); end
        checks++; if (acc_total - f !== 1 || log_we[f[7:0]] !== 1'b1 || log_addr[f[7:0]] !== 32'h100 ||
                      log_strb[f[7:0]] !== 4'b1111 || log_wdata[f[7:0]] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL sw_access: got n=%0d a=%h s=%b d=%h exp 1/100/1111/deadbeef",
                               acc_total - f, log_addr[f[7:0]], log_strb[f[7:0]], log_wdata[f[7:0]]); end
        do_req(1'b1, 3'b000, 32'h103, 32'h000000AB, lat, rd, er, f);
        checks++; if (lat !== 2 || acc_total - f !== 1 || log_addr[f[7:0]] !== 32'h100 ||
                      log_strb[f[7:0]] !== 4'b1000 || log_wdata[f[7:0]] !== 32'hAB000000) begin
            errors++; $display("FAIL sb_access: got lat=%0d n=%0d a=%h s=%b d=%h exp 2/1/100/1000/ab000000",
                               lat, acc_total - f, log_addr[f[7:0]], log_strb[f[7:0]], log_wdata[f[7:0]]); end
    endtask

    task automatic test_split_store();
        int lat, f; logic [31:0] rd; logic er;
        do_req(1'b1, 3'b010, 32'h102, 32'h11223344, lat, rd, er, f);
        checks++; if (lat !== 3 || er !== 1'b0 || acc_total - f !== 2) begin
            errors++; $display("FAIL ssw_rsp: got lat=%0d err=%b n=%0d exp 3/0/2", lat, er, acc_total - f); end
        checks++; if (log_addr[f[7:0]] !== 32'h100 || log_strb[f[7:0]] !== 4'b1100 ||
                      log_wdata[f[7:0]] !== 32'h33440000) begin
            errors++; $display("FAIL ssw_lo: got a=%h s=%b d=%h exp 100/1100/33440000",
                               log_addr[f[7:0]], log_strb[f[7:0]], log_wdata[f[7:0]]); end
        checks++; if (log_addr[(f+1)%256] !== 32'h104 || log_strb[(f+1)%256] !== 4'b0011 ||
                      log_wdata[(f+1)%256] !== 32'h00001122) begin
            errors++; $display("FAIL ssw_hi: got a=%h s=%b d=%h exp 104/0011/00001122",
                               log_addr[(f+1)%256], log_strb[(f+1)%256], log_wdata[(f+1)%256]); end
        do_req(1'b1, 3'b001, 32'hFFFFFFFF, 32'h0000BEEF, lat, rd, er, f);
        checks++; if (lat !== 3 || log_addr[f[7:0]] !== 32'hFFFFFFFC || log_strb[f[7:0]] !== 4'b1000 ||
                      log_wdata[f[7:0]] !== 32'hEF000000 || log_addr[(f+1)%256] !== 32'h0 ||
                      log_strb[(f+1)%256] !== 4'b0001 || log_wdata[(f+1)%256] !== 32'h000000BE) begin
            errors++; $display("FAIL sh_wrap: got lat=%0d a0=%h s0=%b d0=%h a1=%h s1=%b d1=%h exp 3/fffffffc/1000/ef000000/0/0001/be",
                               lat, log_addr[f[7:0]], log_strb[f[7:0]], log_wdata[f[7:0]],
                               log_addr[(f+1)%256], log_strb[(f+1)%256], log_wdata[(f+1)%256]); end
    endtask

    typedef struct { logic [2:0] f3; logic [31:0] a; logic [31:0] exp; } ld_t;

    task automatic test_load();
        int lat, f; logic [31:0] rd; logic er;
        ld_t tbl [7];
        tbl = '{'{3'b000, 32'h101, 32'h0000007F}, '{3'b000, 32'h102, 32'hFFFFFFFF},
                '{3'b101, 32'h102, 32'h000080FF}, '{3'b001, 32'h102, 32'hFFFF80FF},
                '{3'b100, 32'h103, 32'h00000080}, '{3'b010, 32'h100, 32'h80FF7F01},
                '{3'b001, 32'h100, 32'h00007F01}};
        do_req(1'b1, 3'b010, 32'h100, 32'h80FF7F01, lat, rd, er, f);
        for (int i = 0; i < 7; i++) begin
            do_req(1'b0, tbl[i].f3, tbl[i].a, 32'h0, lat, rd, er, f);
            checks++; if (lat !== 3 || er !== 1'b0 || rd !== tbl[i].exp || acc_total - f !== 1 ||
                          log_we[f[7:0]] !== 1'b0 || log_addr[f[7:0]] !== 32'h100) begin
                errors++; $display("FAIL load_%0d: got lat=%0d err=%b d=%h n=%0d a=%h exp 3/0/%h/1/100",
                                   i, lat, er, rd, acc_total - f, log_addr[f[7:0]], tbl[i].exp); end
        end
    endtask

    task automatic test_split_load();
        int lat, f; logic [31:0] rd; logic er;
        do_req(1'b1, 3'b010, 32'h100, 32'hAABBCCDD, lat, rd, er, f);
        do_req(1'b1, 3'b010, 32'h104, 32'h11223344, lat, rd, er, f);
        do_req(1'b0, 3'b010, 32'h103, 32'h0, lat, rd, er, f);
        checks++; if (lat !== 4 || er !== 1'b0 || rd !== 32'h223344AA) begin
            errors++; $display("FAIL slw_rsp: got lat=%0d err=%b d=%h exp 4/0/223344aa", lat, er, rd); end
        checks++; if (acc_total - f !== 2 || log_we[f[7:0]] !== 1'b0 || log_addr[f[7:0]] !== 32'h100 ||
                      log_we[(f+1)%256] !== 1'b0 || log_addr[(f+1)%256] !== 32'h104) begin
            errors++; $display("FAIL slw_access: got n=%0d a0=%h a1=%h exp 2 reads 100/104",
                               acc_total - f, log_addr[f[7:0]], log_addr[(f+1)%256]); end
        do_req(1'b0, 3'b001, 32'h103, 32'h0, lat, rd, er, f);
        checks++; if (lat !== 4 || rd !== 32'h000044AA) begin
            errors++; $display("FAIL slh_rsp: got lat=%0d d=%h exp 4/000044aa", lat, rd); end
    endtask

    task automatic test_errors();
        int lat, f, nb; logic [31:0] rd; logic er;
        do_req(1'b0, 3'b011, 32'h100, 32'h0, lat, rd, er, f);
        checks++; if (lat !== 2 || er !== 1'b1 || rd !== 32'h0 || acc_total - f !== 0) begin
            errors++; $display("FAIL ld_illegal: got lat=%0d err=%b d=%h n=%0d exp 2/1/0/0", lat, er, rd, acc_total - f); end
        do_req(1'b1, 3'b100, 32'h100, 32'h12345678, lat, rd, er, f);
        checks++; if (lat !== 2 || er !== 1'b1 || acc_total - f !== 0) begin
            errors++; $display("FAIL st_illegal: got lat=%0d err=%b n=%0d exp 2/1/0", lat, er, acc_total - f); end
        req_we_i = 1'b0; req_funct3_i = 3'b010; req_addr_i = 32'h103; req_valid_b = 1'b1;
        @(posedge clk);
        #1 req_valid_b = 1'b0;
        lat = -1; nb = 0; er = 1'bx; rd = 32'hxxxx_xxxx;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (b_ren === 1'b1 || b_wen === 1'b1) nb++;
            if (b_rsp_valid === 1'b1 && lat < 0) begin lat = c; er = b_rsp_err; rd = b_rsp_rdata; end
        end
        checks++; if (lat !== 2 || er !== 1'b1 || rd !== 32'h0 || nb !== 0) begin
            errors++; $display("FAIL nosplit_err: got lat=%0d err=%b d=%h acc=%0d exp 2/1/0/0", lat, er, rd, nb); end
    endtask

    task automatic test_back_to_back();
        int lat, f; logic [31:0] rd; logic er;
        do_req(1'b1, 3'b010, 32'h108, 32'hCAFEF00D, lat, rd, er, f);
        checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b exp 1", req_ready_o); end
        do_req(1'b0, 3'b010, 32'h108, 32'h0, lat, rd, er, f);
        checks++; if (lat !== 3 || rd !== 32'hCAFEF00D) begin
            errors++; $display("FAIL b2b_load: got lat=%0d d=%h exp 3/cafef00d", lat, rd); end
    endtask

    task automatic test_reset_midop();
        int lat, f, nv; logic [31:0] rd; logic er;
        do_req(1'b1, 3'b010, 32'h104, 32'h55667788, lat, rd, er, f);
        do_req(1'b1, 3'b010, 32'h100, 32'h00000000, lat, rd, er, f);
        req_we_i = 1'b1; req_funct3_i = 3'b010; req_addr_i = 32'h102; req_wdata_i = 32'h11223344;
        req_valid_i = 1'b1;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        @(posedge clk);
        #2;
        checks++; if (dmem_wen_o !== 1'b1 || dmem_addr_o !== 32'h104) begin
            errors++; $display("FAIL midop_acc1: got w=%b a=%h exp 1/104", dmem_wen_o, dmem_addr_o); end
        rst_n = 1'b0;
        #1;
        checks++; if (dmem_wen_o !== 1'b0 || dmem_ren_o !== 1'b0 || dmem_addr_o !== 32'h0 ||
                      dmem_wstrb_o !== 4'h0 || dmem_wdata_o !== 32'h0 || req_ready_o !== 1'b1) begin
            errors++; $display("FAIL midop_idle: got w=%b r=%b a=%h s=%b rdy=%b exp 0/0/0/0/1",
                               dmem_wen_o, dmem_ren_o, dmem_addr_o, dmem_wstrb_o, req_ready_o); end
        @(negedge clk); rst_n = 1'b1;
        nv = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (rsp_valid_o !== 1'b0) nv++;
        end
        checks++; if (nv !== 0) begin errors++; $display("FAIL midop_norsp: got %0d pulses exp 0", nv); end
        do_req(1'b0, 3'b010, 32'h100, 32'h0, lat, rd, er, f);
        checks++; if (rd !== 32'h33440000) begin errors++; $display("FAIL midop_lo: got %h exp 33440000", rd); end
        do_req(1'b0, 3'b010, 32'h104, 32'h0, lat, rd, er, f);
        checks++; if (rd !== 32'h55667788) begin errors++; $display("FAIL midop_hi: got %h exp 55667788", rd); end
    endtask

    task automatic test_no_overlap();
        checks++; if (overlap_cnt !== 0) begin errors++; $display("FAIL ren_wen_overlap: got %0d exp 0", overlap_cnt); end
    endtask

    initial begin
        test_reset();
        test_store();
        test_split_store();
        test_load();
        test_split_load();
        test_errors();
        test_back_to_back();
        test_reset_midop();
        test_no_overlap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
